// File: rtl/fb_write_arbiter_if.sv
// Frame-buffer write-port bundle: engine request side plus port-A RAM drive,
// grant/error status and the clear sequencer handshake.
interface fb_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 12
);
    logic                             clear_start;
    logic                             clear_busy;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
    logic                             ram_en;
    logic                             ram_we;
    logic [ADDR_WIDTH-1:0]            ram_addr;
    logic [DATA_WIDTH-1:0]            ram_din;
    logic [2:0]                       grant_id;
    logic                             addr_err;

    modport slave (
        input  clear_start, req_valid, req_addr, req_data,
        output clear_busy, req_ready, ram_en, ram_we, ram_addr, ram_din,
               grant_id, addr_err
    );

    modport master (
        output clear_start, req_valid, req_addr, req_data,
        input  clear_busy, req_ready, ram_en, ram_we, ram_addr, ram_din,
               grant_id, addr_err
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing frame-buffer port A between iteration engines,
// with a built-in sweep that fills the whole buffer with CLEAR_VALUE.
module fb_write_lane #(
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 4800
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  in_range
);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);
    assign in_range = ({1'b0, addr} < LIMIT);
endmodule

module fb_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DEPTH          = 4800,
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 12,
    parameter int CLEAR_VALUE    = 0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fb_write_arbiter_if.slave    bus
);
    typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

    localparam state_t          RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
    localparam logic [2:0]      LAST_IDX  = 3'(NUM_REQ - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                                state, state_nxt;
    logic [ADDR_WIDTH-1:0]                 clr_cnt;
    logic                                  clr_last;
    logic [2:0]                            rr;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    addr_lane;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    data_lane;
    logic [NUM_REQ-1:0]                    in_range;
    logic [NUM_REQ-1:0]                    cand;
    logic [NUM_REQ-1:0]                    ready;
    logic [2:0]                            gidx;
    logic                                  found;
    logic [ADDR_WIDTH-1:0]                 sel_addr;
    logic [DATA_WIDTH-1:0]                 sel_data;
    logic                                  sel_ok;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign addr_lane[g] = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_lane[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
        fb_write_lane #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_lane (
            .addr     (addr_lane[g]),
            .in_range (in_range[g])
        );
    end

    assign clr_last = (clr_cnt == LAST_ADDR);

    // Round-robin pick: first valid at or above rr, otherwise first valid below it.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && bus.req_valid[j] && (3'(j) >= rr)) begin
                found = 1'b1;
                gidx  = 3'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && bus.req_valid[j]) begin
                found = 1'b1;
                gidx  = 3'(j);
            end
        end
        cand = '0;
        for (int j = 0; j < NUM_REQ; j++)
            cand[j] = found && (gidx == 3'(j));
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (ready[j]) begin
                sel_addr = sel_addr | addr_lane[j];
                sel_data = sel_data | data_lane[j];
            end
        end
        sel_ok = |(ready & in_range);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST_STATE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (bus.clear_start) state_nxt = CLEAR;
            CLEAR:   if (clr_last)        state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // FSM: outputs; a clear request blocks grants in the cycle it arrives
    always_comb begin
        bus.clear_busy = (state == CLEAR);
        ready          = (state == RUN && !bus.clear_start) ? cand : '0;
        bus.req_ready  = ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt      <= '0;
            rr           <= '0;
            bus.ram_en   <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_din  <= '0;
            bus.grant_id <= '0;
            bus.addr_err <= 1'b0;
        end else begin
            bus.ram_en <= 1'b0;
            bus.ram_we <= 1'b0;
            if (state == CLEAR) begin
                bus.ram_en   <= 1'b1;
                bus.ram_we   <= 1'b1;
                bus.ram_addr <= clr_cnt;
                bus.ram_din  <= DATA_WIDTH'(CLEAR_VALUE);
                clr_cnt      <= clr_last ? '0 : clr_cnt + 1'b1;
            end else if (bus.clear_start) begin
                clr_cnt <= '0;
            end else if (|ready) begin
                // Out-of-range requests are consumed but never reach the RAM.
                bus.grant_id <= gidx;
                rr           <= (gidx == LAST_IDX) ? 3'd0 : gidx + 3'd1;
                bus.ram_addr <= sel_addr;
                bus.ram_din  <= sel_data;
                bus.ram_en   <= sel_ok;
                bus.ram_we   <= sel_ok;
                if (!sel_ok) bus.addr_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized bench for fb_write_arbiter against a cycle-level behavioural model
// of the arbitration, clear sweep and sticky error rules.
module tb_fb_write_arbiter;
    localparam int N     = 4;
    localparam int AW    = 13;
    localparam int DW    = 12;
    localparam int DEPTH = 4800;
    localparam int CV    = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fb_write_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fb_write_arbiter #(
        .NUM_REQ(N), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt;

    bit m_clear, m_err, e_en;
    int m_cnt, m_rr, m_gid, e_addr, e_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_clear = 1'b1; m_cnt = 0; m_rr = 0; m_gid = 0; m_err = 1'b0;
        e_en = 1'b0; e_addr = 0; e_din = 0;
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int d);
        bus.req_valid[i]         = v;
        bus.req_addr[i*AW +: AW] = AW'(a);
        bus.req_data[i*DW +: DW] = DW'(d);
    endtask

    task automatic rand_reqs(input int pct, input bit allow_oor);
        for (int i = 0; i < N; i++) begin
            int a;
            a = (allow_oor && $urandom_range(15) == 0) ? int'($urandom_range(8191, DEPTH))
                                                       : int'($urandom_range(DEPTH-1));
            set_req(i, $urandom_range(99) < pct, a, int'($urandom_range(4095)));
        end
    endtask

    // One clock: inputs already driven after a falling edge.
    task automatic tick();
        int g;
        logic [N-1:0] er;
        #1;
        g  = -1;
        er = '0;
        if (!m_clear && !bus.clear_start)
            for (int k = 0; k < N; k++)
                if (g < 0 && bus.req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("clear_busy", 32'(bus.clear_busy), 32'(m_clear));
        if (bus.clear_busy) busy_cnt++;

        if (m_clear) begin
            e_en = 1'b1; e_addr = m_cnt; e_din = CV;
            m_cnt++;
            if (m_cnt == DEPTH) begin m_clear = 1'b0; m_cnt = 0; end
        end else if (bus.clear_start) begin
            m_clear = 1'b1; m_cnt = 0; e_en = 1'b0;
        end else if (g >= 0) begin
            m_gid = g;
            m_rr  = (g + 1) % N;
            e_addr = int'(bus.req_addr[g*AW +: AW]);
            e_din  = int'(bus.req_data[g*DW +: DW]);
            e_en   = (e_addr < DEPTH);
            if (!e_en) m_err = 1'b1;
        end else begin
            e_en = 1'b0;
        end

        @(posedge clk); #1;
        chk("ram_en", 32'(bus.ram_en), 32'(e_en));
        chk("ram_we", 32'(bus.ram_we), 32'(e_en));
        chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
        chk("addr_err", 32'(bus.addr_err), 32'(m_err));
        if (e_en) begin
            chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
            chk("ram_din", 32'(bus.ram_din), 32'(e_din));
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(bus.clear_busy), 32'd1);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_en"},    32'(bus.ram_en), 32'd0);
        chk({tag, "_we"},    32'(bus.ram_we), 32'd0);
        chk({tag, "_addr"},  32'(bus.ram_addr), 32'd0);
        chk({tag, "_din"},   32'(bus.ram_din), 32'd0);
        chk({tag, "_gid"},   32'(bus.grant_id), 32'd0);
        chk({tag, "_err"},   32'(bus.addr_err), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 5000000 required");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.clear_start = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (3) @(negedge clk);
        #1 chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Power-on sweep with engines knocking the whole time
        busy_cnt = 0;
        repeat (DEPTH) begin rand_reqs(50, 1'b0); tick(); end
        chk("sweep_len", 32'(busy_cnt), DEPTH);
        bus.req_valid = '0;
        tick();

        // Single engine 2 write
        set_req(2, 1'b1, 100, 'hABC);
        tick();
        chk("e2_we", 32'(bus.ram_we), 32'd1);
        chk("e2_addr", 32'(bus.ram_addr), 32'd100);
        chk("e2_din", 32'(bus.ram_din), 32'hABC);
        chk("e2_gid", 32'(bus.grant_id), 32'd2);

        // Engine 3 alone moves the pointer back to 0, then all four contend
        bus.req_valid = '0;
        set_req(3, 1'b1, 5, 1);
        tick();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'b1, int'($urandom_range(DEPTH-1)), int'($urandom_range(4095)));
            tick();
            chk("rr_order", 32'(bus.grant_id), 32'(k % N));
        end

        // Engine 1 alone leaves rr at 2, then engines 1 and 3 contend
        bus.req_valid = '0;
        set_req(1, 1'b1, 7, 2);
        tick();
        set_req(3, 1'b1, 30, 3);
        tick();
        chk("rr2_first", 32'(bus.grant_id), 32'd3);
        tick();
        chk("rr2_second", 32'(bus.grant_id), 32'd1);

        // Out-of-range write is consumed, not written, and sticks
        bus.req_valid = '0;
        set_req(0, 1'b1, DEPTH, 'h123);
        tick();
        chk("oor_we", 32'(bus.ram_we), 32'd0);
        chk("oor_err", 32'(bus.addr_err), 32'd1);
        bus.req_valid = '0;
        set_req(2, 1'b1, DEPTH-1, 'h456);
        tick();
        chk("oor_after_we", 32'(bus.ram_we), 32'd1);
        chk("oor_sticky", 32'(bus.addr_err), 32'd1);

        repeat (400) begin rand_reqs(60, 1'b1); tick(); end

        // clear_start beats a pending engine 1 request; restart attempt ignored
        bus.req_valid = '0;
        set_req(1, 1'b1, 200, 'h777);
        bus.clear_start = 1'b1;
        busy_cnt = 0;
        tick();
        bus.clear_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 2000) bus.clear_start = 1'b1;
            tick();
            bus.clear_start = 1'b0;
        end
        chk("clear_len", 32'(busy_cnt), DEPTH);
        tick();
        chk("post_clear_gid", 32'(bus.grant_id), 32'd1);
        chk("post_clear_addr", 32'(bus.ram_addr), 32'd200);

        // Asynchronous reset in the middle of a sweep
        bus.req_valid = '0;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        repeat (100) begin rand_reqs(50, 1'b0); tick(); end
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (20) begin rand_reqs(50, 1'b0); tick(); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single write port (port A) of the dual-port frame-buffer block RAM between NUM_REQ Mandelbrot iteration engines; the VGA scan-out keeps port B.
- Round-robin arbitration over valid/ready requesters; one registered RAM write per cycle.
- Built-in clear sequencer sweeps the whole frame buffer with CLEAR_VALUE before a new frame is rendered.

Parameters:
- NUM_REQ, 4, number of requesting engines (2..8).
- DEPTH, 4800, frame-buffer words; valid addresses 0..DEPTH-1.
- ADDR_WIDTH, 13, RAM address width; 2^ADDR_WIDTH >= DEPTH.
- DATA_WIDTH, 12, pixel word width.
- CLEAR_VALUE, 0, word written during clear.
- CLEAR_ON_RESET, 1, 1 = start a clear sweep on reset release.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear_start  in  1  single-cycle pulse requesting a full clear sweep.
- clear_busy  out  1  high while the clear sweep runs.
- req_valid  in  NUM_REQ  per-engine write request.
- req_ready  out  NUM_REQ  per-engine grant; one-hot or zero.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; engine i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed pixel data, same packing.
- ram_en  out  1  to port A ena.
- ram_we  out  1  to port A wea.
- ram_addr  out  ADDR_WIDTH  to port A addra.
- ram_din  out  DATA_WIDTH  to port A dia.
- grant_id  out  3  index of the engine granted in the previous cycle.
- addr_err  out  1  sticky flag: an out-of-range address was accepted.

Behaviour:
- States: RUN and CLEAR.
- Reset values: state = CLEAR if CLEAR_ON_RESET, else RUN.
  - clear counter 0; rr pointer 0.
  - ram_en/ram_we 0; ram_addr 0; ram_din 0; grant_id 0; addr_err 0.
  - clear_busy = (state == CLEAR).
- RUN:
  - req_ready is combinational from req_valid and the rr pointer.
  - Grant the first valid engine searching from index rr upward, wrapping modulo NUM_REQ.
  - Transfer = req_valid[i] & req_ready[i].
  - On a transfer, the next rising edge registers ram_addr/ram_din from engine i, sets ram_en = ram_we = 1, sets grant_id = i, and sets rr = (i+1) mod NUM_REQ.
  - No transfer: ram_en = ram_we = 0 next cycle; rr holds.
  - Write latency: request accepted in cycle t, RAM write edge at t+1.
  - Sustained throughput is 1 write/cycle.
  - Fairness: a continuously valid engine waits at most NUM_REQ-1 grants.
- Out-of-range address (>= DEPTH):
  - Request is still accepted (ready asserted) but not written: ram_en = ram_we = 0.
  - addr_err set to 1 and holds until reset.
- clear_start in RUN:
  - Takes priority; req_ready = 0 in that cycle.
  - Next cycle: state = CLEAR, counter = 0.
- CLEAR:
  - req_ready = 0 for all engines.
  - Each cycle: ram_en = ram_we = 1, ram_addr = counter, ram_din = CLEAR_VALUE, counter increments.
  - After the write of address DEPTH-1: state = RUN, clear_busy falls, counter returns to 0.
  - Sweep takes exactly DEPTH cycles.
  - clear_start during CLEAR is ignored; no restart.
- Registered outputs of a grant issued in the last RUN cycle still drive their write in the first CLEAR cycle. The sweep starts one cycle later in that case, or overwrites it; either way the clear completes the full range.
- Reset asserted mid-sweep or mid-write:
  - All outputs return to reset values immediately (asynchronous).
  - The partial RAM contents are left as they are.
- Port B is untouched by this block.
- grant_id width is fixed at 3 bits; upper bits are 0 when NUM_REQ < 8.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=4800 -> clear_busy high for exactly 4800 cycles; writes to addresses 0..4799 with data 0; req_ready stays 0 throughout; then RUN.
- RUN, only engine 2 valid, addr 100, data 0xABC -> req_ready = 0100 that cycle; next cycle ram_we = 1, ram_addr = 100, ram_din = 0xABC, grant_id = 2.
- All 4 engines valid continuously, rr = 0 -> grant order 0,1,2,3,0,1…; one write every cycle; no engine skipped.
- Engines 1 and 3 valid, rr = 2 -> engine 3 granted first, then 1; rr ends at 2.
- Engine 0 writes addr 4800 -> accepted; ram_we stays 0; addr_err = 1 and stays 1 through later valid writes.
- clear_start in the same cycle engine 1 is valid -> req_ready = 0; full sweep runs; a second clear_start mid-sweep is ignored; engine 1 is granted in the first RUN cycle after the sweep.
